// File: rtl/wb_arbiter_2m_if.sv
// Wishbone classic bus bundle shared by the two requesters and the target.
// 32-bit address and data, 4-bit byte select.
interface wshb_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [31:0] dat_ms;
   logic        ack;
   logic        err;
   logic [31:0] dat_sm;

   modport master (output cyc, stb, we, adr, sel, dat_ms, input ack, err, dat_sm);
   modport slave  (input cyc, stb, we, adr, sel, dat_ms, output ack, err, dat_sm);
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-requester Wishbone arbiter, non-preemptive with round-robin tie break.
// Optional ack watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_2m #(
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   wshb_if.slave      wb_m0,
   wshb_if.slave      wb_m1,
   wshb_if.master     wb_s,
   output logic [1:0] grant
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   r_last_served;   // 1'b0 = m0, 1'b1 = m1
   logic   w_timeout;
   logic   w_err_fwd;

   // State register and last-served history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_last_served <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == GNT0 && w_state_nxt != GNT0) begin
            r_last_served <= 1'b0;
         end else if (r_state == GNT1 && w_state_nxt != GNT1) begin
            r_last_served <= 1'b1;
         end else begin
            r_last_served <= r_last_served;
         end
      end
   end

   // Next-state: the owner keeps the bus for as long as it holds cyc.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (wb_m0.cyc && wb_m1.cyc) begin
               if (r_last_served) w_state_nxt = GNT0;
               else               w_state_nxt = GNT1;
            end else if (wb_m0.cyc) begin
               w_state_nxt = GNT0;
            end else if (wb_m1.cyc) begin
               w_state_nxt = GNT1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         GNT0: begin
            if (wb_m0.cyc)      w_state_nxt = GNT0;
            else if (wb_m1.cyc) w_state_nxt = GNT1;
            else                w_state_nxt = IDLE;
         end
         GNT1: begin
            if (wb_m1.cyc)      w_state_nxt = GNT1;
            else if (wb_m0.cyc) w_state_nxt = GNT0;
            else                w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   logic [CW-1:0] r_tmo_cnt;
   logic          w_owner_stb;

   // Strobe of whichever master currently owns the bus.
   always_comb begin
      case (r_state)
         GNT0:    w_owner_stb = wb_m0.stb;
         GNT1:    w_owner_stb = wb_m1.stb;
         default: w_owner_stb = 1'b0;
      endcase
   end

   // Fires on the last permitted waiting cycle; ignoring ack here keeps stb masking loop-free.
   assign w_timeout = w_owner_stb && (r_tmo_cnt == CW'(TIMEOUT - 1));
   assign w_err_fwd = w_timeout | wb_s.err;

   // Waiting-cycle counter for the owner's outstanding strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmo_cnt <= {CW{1'b0}};
      end else if ((w_state_nxt != r_state) || w_timeout || !w_owner_stb || wb_s.ack) begin
         r_tmo_cnt <= {CW{1'b0}};
      end else begin
         r_tmo_cnt <= r_tmo_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
   end
`else
   assign w_timeout = 1'b0;
   assign w_err_fwd = 1'b0;
`endif

   // Output decode: route the owner to the target and the target's response back to the owner only.
   always_comb begin
      grant        = 2'b00;
      wb_s.cyc     = 1'b0;
      wb_s.stb     = 1'b0;
      wb_s.we      = 1'b0;
      wb_s.adr     = 32'h0000_0000;
      wb_s.sel     = 4'h0;
      wb_s.dat_ms  = 32'h0000_0000;
      wb_m0.ack    = 1'b0;
      wb_m0.err    = 1'b0;
      wb_m1.ack    = 1'b0;
      wb_m1.err    = 1'b0;
      wb_m0.dat_sm = wb_s.dat_sm;
      wb_m1.dat_sm = wb_s.dat_sm;
      case (r_state)
         GNT0: begin
            grant       = 2'b01;
            wb_s.cyc    = wb_m0.cyc;
            wb_s.stb    = wb_m0.stb & ~w_timeout;
            wb_s.we     = wb_m0.we;
            wb_s.adr    = wb_m0.adr;
            wb_s.sel    = wb_m0.sel;
            wb_s.dat_ms = wb_m0.dat_ms;
            wb_m0.ack   = wb_s.ack;
            wb_m0.err   = w_err_fwd;
         end
         GNT1: begin
            grant       = 2'b10;
            wb_s.cyc    = wb_m1.cyc;
            wb_s.stb    = wb_m1.stb & ~w_timeout;
            wb_s.we     = wb_m1.we;
            wb_s.adr    = wb_m1.adr;
            wb_s.sel    = wb_m1.sel;
            wb_s.dat_ms = wb_m1.dat_ms;
            wb_m1.ack   = wb_s.ack;
            wb_m1.err   = w_err_fwd;
         end
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: directed scenarios plus random traffic against a
// request/ownership reference model and a behavioural block-RAM target.
module tb_wb_arbiter_2m;
   localparam int TMO = 4;

   logic       clk;
   logic       rst_n;
   logic [1:0] grant;
   int         n_checks;
   int         n_errors;

   wshb_if m0_if ();
   wshb_if m1_if ();
   wshb_if s_if ();

   wb_arbiter_2m #(.TIMEOUT(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb_m0 (m0_if),
      .wb_m1 (m1_if),
      .wb_s  (s_if),
      .grant (grant)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Block RAM target: write ack same cycle, read ack one cycle after strobe.
   logic [31:0] mem [0:255];
   logic        slv_no_ack;
   logic        rd_ack;
   logic [31:0] rd_dat;
   logic        wr_hit;
   assign wr_hit      = s_if.cyc & s_if.stb & s_if.we;
   assign s_if.ack    = ~slv_no_ack & (wr_hit | rd_ack);
   assign s_if.err    = 1'b0;
   assign s_if.dat_sm = rd_dat;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ack <= 1'b0;
      end else begin
         if (wr_hit && !slv_no_ack) mem[s_if.adr[9:2]] <= s_if.dat_ms;
         if (s_if.cyc && s_if.stb && !s_if.we) rd_dat <= mem[s_if.adr[9:2]];
         rd_ack <= s_if.cyc & s_if.stb & ~s_if.we & ~rd_ack & ~slv_no_ack;
      end
   end

   // Reference model: owner 0=none, 1=m0, 2=m1; the owner keeps the bus while it
   // holds cyc, otherwise the requesters compete and a tie goes to the one not served last.
   int exp_owner;
   int exp_last;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_owner <= 0;
         exp_last  <= 2;
      end else if (exp_owner == 1 && m0_if.cyc) begin
         exp_owner <= 1;
      end else if (exp_owner == 2 && m1_if.cyc) begin
         exp_owner <= 2;
      end else begin
         if (exp_owner != 0) exp_last <= exp_owner;
         if (m0_if.cyc && m1_if.cyc) exp_owner <= 3 - exp_last;
         else if (m0_if.cyc)         exp_owner <= 1;
         else if (m1_if.cyc)         exp_owner <= 2;
         else                        exp_owner <= 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_m0(input logic c, input logic s, input logic w, input logic [31:0] a, input logic [31:0] d);
      m0_if.cyc = c; m0_if.stb = s; m0_if.we = w; m0_if.adr = a; m0_if.dat_ms = d; m0_if.sel = 4'hF;
   endtask

   task automatic drv_m1(input logic c, input logic s, input logic w, input logic [31:0] a, input logic [31:0] d);
      m1_if.cyc = c; m1_if.stb = s; m1_if.we = w; m1_if.adr = a; m1_if.dat_ms = d; m1_if.sel = 4'hF;
   endtask

   task automatic idle_all();
      drv_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drv_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic apply_reset();
      tick();
      idle_all();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      drv_m0(1'b1, 1'b1, 1'b1, 32'h44, 32'h1234_5678);
      tick();
      #2;
      n_checks++;
      if (grant !== 2'b00) begin n_errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
      n_checks++;
      if ({s_if.cyc, s_if.stb, s_if.we, s_if.adr, s_if.sel, s_if.dat_ms} !== 71'd0) begin
         n_errors++; $display("FAIL reset_bus: got cyc=%b stb=%b adr=%h expected all zero", s_if.cyc, s_if.stb, s_if.adr);
      end
      n_checks++;
      if ({m0_if.ack, m0_if.err, m1_if.ack, m1_if.err} !== 4'b0000) begin
         n_errors++; $display("FAIL reset_resp: got %b expected 0000", {m0_if.ack, m0_if.err, m1_if.ack, m1_if.err});
      end
      tick();
      idle_all();
      rst_n = 1'b1;
   endtask

   task automatic test_write();
      tick();
      drv_m0(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
      #2;
      n_checks++;
      if (grant !== 2'b00) begin n_errors++; $display("FAIL wr_pre_grant: got %b expected 00", grant); end
      tick();
      #2;
      n_checks++;
      if (grant !== 2'b01) begin n_errors++; $display("FAIL wr_grant: got %b expected 01", grant); end
      n_checks++;
      if ({s_if.cyc, s_if.stb, s_if.we, s_if.adr, s_if.sel, s_if.dat_ms} !== {3'b111, 32'h10, 4'hF, 32'hDEAD_BEEF}) begin
         n_errors++; $display("FAIL wr_bus: got adr=%h dat=%h sel=%h expected 10 deadbeef f", s_if.adr, s_if.dat_ms, s_if.sel);
      end
      n_checks++;
      if (m0_if.ack !== 1'b1 || m0_if.ack !== s_if.ack) begin
         n_errors++; $display("FAIL wr_ack_m0: got %b expected 1", m0_if.ack);
      end
      n_checks++;
      if (m1_if.ack !== 1'b0) begin n_errors++; $display("FAIL wr_ack_m1: got %b expected 0", m1_if.ack); end
      tick();
      idle_all();
      tick();
      #2;
      n_checks++;
      if (grant !== 2'b00) begin n_errors++; $display("FAIL wr_release: got %b expected 00", grant); end
   endtask

   task automatic test_read();
      tick();
      drv_m1(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
      tick();
      #2;
      n_checks++;
      if (grant !== 2'b10 || m1_if.ack !== 1'b0 || m0_if.ack !== 1'b0) begin
         n_errors++; $display("FAIL rd_first: got grant=%b ack1=%b ack0=%b expected 10 0 0", grant, m1_if.ack, m0_if.ack);
      end
      tick();
      #2;
      n_checks++;
      if (m1_if.ack !== 1'b1 || m1_if.dat_sm !== 32'hDEAD_BEEF) begin
         n_errors++; $display("FAIL rd_data: got ack=%b dat=%h expected 1 deadbeef", m1_if.ack, m1_if.dat_sm);
      end
      n_checks++;
      if (m0_if.ack !== 1'b0 || m0_if.dat_sm !== 32'hDEAD_BEEF) begin
         n_errors++; $display("FAIL rd_other: got ack0=%b dat0=%h expected 0 deadbeef", m0_if.ack, m0_if.dat_sm);
      end
      idle_all();
      tick();
   endtask

   task automatic test_arbitration();
      apply_reset();
      m0_if.cyc = 1'b1; m1_if.cyc = 1'b1;
      #2;
      n_checks++;
      if (grant !== 2'b00) begin n_errors++; $display("FAIL tie_pre: got %b expected 00", grant); end
      tick(); #2;
      n_checks++;
      if (grant !== 2'b01) begin n_errors++; $display("FAIL tie_first: got %b expected 01", grant); end
      tick(); #2;
      n_checks++;
      if (grant !== 2'b01) begin n_errors++; $display("FAIL tie_hold: got %b expected 01", grant); end
      m0_if.cyc = 1'b0;
      tick(); #2;
      n_checks++;
      if (grant !== 2'b10) begin n_errors++; $display("FAIL handover: got %b expected 10", grant); end
      m1_if.cyc = 1'b0;
      tick();
      m0_if.cyc = 1'b1;
      tick();
      m0_if.cyc = 1'b0;
      tick();
      m0_if.cyc = 1'b1; m1_if.cyc = 1'b1;
      tick(); #2;
      n_checks++;
      if (grant !== 2'b10) begin n_errors++; $display("FAIL tie_repeat: got %b expected 10", grant); end
      m1_if.cyc = 1'b0;
      tick(); #2;
      n_checks++;
      if (grant !== 2'b01) begin n_errors++; $display("FAIL back_to_m0: got %b expected 01", grant); end
      m0_if.cyc = 1'b0; m1_if.cyc = 1'b1;
      tick(); #2;
      n_checks++;
      if (grant !== 2'b10) begin n_errors++; $display("FAIL swap_same_edge: got %b expected 10", grant); end
      idle_all();
      m0_if.stb = 1'b1;
      tick();
      tick(); #2;
      n_checks++;
      if (grant !== 2'b00 || s_if.stb !== 1'b0) begin
         n_errors++; $display("FAIL stb_no_cyc: got grant=%b stb=%b expected 00 0", grant, s_if.stb);
      end
      idle_all();
   endtask

   task automatic test_burst();
      tick();
      drv_m0(1'b1, 1'b1, 1'b1, 32'h20, 32'h0);
      tick();
      for (int b = 0; b < 4; b++) begin
         m0_if.adr    = 32'h20 + 32'(4 * b);
         m0_if.dat_ms = $urandom;
         if (b == 1) drv_m1(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
         #2;
         n_checks++;
         if (grant !== 2'b01 || m0_if.ack !== 1'b1 || m1_if.ack !== 1'b0) begin
            n_errors++; $display("FAIL burst_beat%0d: got grant=%b ack0=%b ack1=%b expected 01 1 0", b, grant, m0_if.ack, m1_if.ack);
         end
         tick();
      end
      drv_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick(); #2;
      n_checks++;
      if (grant !== 2'b10 || m1_if.ack !== 1'b0) begin
         n_errors++; $display("FAIL burst_handover: got grant=%b ack1=%b expected 10 0", grant, m1_if.ack);
      end
      tick(); #2;
      n_checks++;
      if (m1_if.ack !== 1'b1 || m1_if.dat_sm !== 32'hDEAD_BEEF) begin
         n_errors++; $display("FAIL burst_m1_read: got ack=%b dat=%h expected 1 deadbeef", m1_if.ack, m1_if.dat_sm);
      end
      idle_all();
      tick();
   endtask

   task automatic test_timeout();
      logic exp_err;
      tick();
      slv_no_ack = 1'b1;
      drv_m0(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
      tick();
      for (int k = 1; k <= 6; k++) begin
         #2;
`ifdef WB_ARB_TIMEOUT_EN
         exp_err = (k == TMO);
`else
         exp_err = 1'b0;
`endif
         n_checks++;
         if (m0_if.err !== exp_err || s_if.stb !== ~exp_err || grant !== 2'b01 || m1_if.err !== 1'b0) begin
            n_errors++; $display("FAIL timeout_cyc%0d: got err=%b stb=%b grant=%b expected err=%b stb=%b grant=01",
                                 k, m0_if.err, s_if.stb, grant, exp_err, ~exp_err);
         end
         tick();
      end
      idle_all();
      slv_no_ack = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      tick();
      drv_m1(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
      tick(); #2;
      n_checks++;
      if (grant !== 2'b10 || s_if.cyc !== 1'b1) begin
         n_errors++; $display("FAIL rstmid_pre: got grant=%b cyc=%b expected 10 1", grant, s_if.cyc);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (s_if.cyc !== 1'b0 || s_if.stb !== 1'b0 || grant !== 2'b00 || m1_if.ack !== 1'b0) begin
         n_errors++; $display("FAIL rstmid_async: got cyc=%b stb=%b grant=%b ack=%b expected 0 0 00 0", s_if.cyc, s_if.stb, grant, m1_if.ack);
      end
      tick(); #2;
      n_checks++;
      if (m1_if.ack !== 1'b0 || grant !== 2'b00) begin
         n_errors++; $display("FAIL rstmid_hold: got ack=%b grant=%b expected 0 00", m1_if.ack, grant);
      end
      idle_all();
      m0_if.cyc = 1'b1;
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (grant !== 2'b00) begin n_errors++; $display("FAIL rstrel_pre: got %b expected 00", grant); end
      tick(); #2;
      n_checks++;
      if (grant !== 2'b01) begin n_errors++; $display("FAIL rstrel_first: got %b expected 01", grant); end
      idle_all();
      tick();
   endtask

   task automatic test_random();
      logic [1:0]  exp_g;
      logic [70:0] exp_bus;
      logic [70:0] act_bus;
      for (int i = 0; i < 300; i++) begin
         tick();
         if ($urandom_range(0, 7) == 0) m0_if.cyc = ~m0_if.cyc;
         if ($urandom_range(0, 7) == 0) m1_if.cyc = ~m1_if.cyc;
         m0_if.stb    = m0_if.cyc ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
         m1_if.stb    = m1_if.cyc ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
         m0_if.we     = 1'($urandom_range(0, 1));
         m1_if.we     = 1'($urandom_range(0, 1));
         m0_if.adr    = 32'($urandom_range(8, 63)) << 2;
         m1_if.adr    = 32'($urandom_range(8, 63)) << 2;
         m0_if.sel    = 4'($urandom_range(0, 15));
         m1_if.sel    = 4'($urandom_range(0, 15));
         m0_if.dat_ms = $urandom;
         m1_if.dat_ms = $urandom;
         #2;
         exp_g = (exp_owner == 1) ? 2'b01 : ((exp_owner == 2) ? 2'b10 : 2'b00);
         if (exp_owner == 1)
            exp_bus = {m0_if.cyc, m0_if.stb, m0_if.we, m0_if.adr, m0_if.sel, m0_if.dat_ms};
         else if (exp_owner == 2)
            exp_bus = {m1_if.cyc, m1_if.stb, m1_if.we, m1_if.adr, m1_if.sel, m1_if.dat_ms};
         else
            exp_bus = 71'd0;
         act_bus = {s_if.cyc, s_if.stb, s_if.we, s_if.adr, s_if.sel, s_if.dat_ms};
         n_checks++;
         if (grant !== exp_g) begin n_errors++; $display("FAIL rnd_grant[%0d]: got %b expected %b", i, grant, exp_g); end
         n_checks++;
         if (act_bus !== exp_bus) begin n_errors++; $display("FAIL rnd_bus[%0d]: got %h expected %h", i, act_bus, exp_bus); end
         n_checks++;
         if (m0_if.ack !== ((exp_owner == 1) ? s_if.ack : 1'b0)) begin
            n_errors++; $display("FAIL rnd_ack0[%0d]: got %b owner=%0d slave_ack=%b", i, m0_if.ack, exp_owner, s_if.ack);
         end
         n_checks++;
         if (m1_if.ack !== ((exp_owner == 2) ? s_if.ack : 1'b0)) begin
            n_errors++; $display("FAIL rnd_ack1[%0d]: got %b owner=%0d slave_ack=%b", i, m1_if.ack, exp_owner, s_if.ack);
         end
         n_checks++;
         if ({m0_if.err, m1_if.err} !== 2'b00) begin
            n_errors++; $display("FAIL rnd_err[%0d]: got %b expected 00", i, {m0_if.err, m1_if.err});
         end
         n_checks++;
         if (m0_if.dat_sm !== s_if.dat_sm || m1_if.dat_sm !== s_if.dat_sm) begin
            n_errors++; $display("FAIL rnd_dat[%0d]: got %h/%h expected %h", i, m0_if.dat_sm, m1_if.dat_sm, s_if.dat_sm);
         end
      end
      idle_all();
      tick();
      tick();
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      slv_no_ack = 1'b0;
      rst_n      = 1'b0;
      idle_all();
      test_reset();
      test_write();
      test_read();
      test_arbitration();
      test_burst();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning: max cycles a granted strobe waits for ack (used only with WB_ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1, system clock (all logic on rising edge).
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous assertion, active-low.
REQ-004 SHALL have port wb_m0, wshb_if.slave, 32b adr/dat, 4b sel, requester 0 (cyc, stb, we, adr, sel, dat_ms in; ack, err, dat_sm out).
REQ-005 SHALL have port wb_m1, wshb_if.slave, same widths, requester 1.
REQ-006 SHALL have port wb_s, wshb_if.master, same widths, shared target (the block RAM slave).
REQ-007 SHALL have port grant, output, 2, one-hot current owner (01=m0, 10=m1, 00=none).

Function
REQ-008 SHALL implement FSM with states IDLE, GNT0, GNT1; grant is a decode of state.
REQ-009 IDLE: only m0.cyc -> GNT0; only m1.cyc -> GNT1; both -> the master not in last_served; none -> stay IDLE.
REQ-010 GNTx: stay while mx.cyc=1; on mx.cyc=0 -> GNTy if my.cyc=1, else IDLE; last_served updated to x on leaving GNTx.
REQ-011 Grant SHALL never change while the owner holds cyc (no preemption, bursts/RMW atomic).
REQ-012 Arbitration latency: request in IDLE -> grant next rising edge; zero dead cycles on handover GNTx->GNTy.
REQ-013 wb_s.cyc/stb/we/adr/sel/dat_ms SHALL be combinational copies of the owner's signals; in IDLE cyc=stb=we=0, adr/sel/dat_ms=0.
REQ-014 wb_s.ack SHALL route only to owner; non-owner ack=0 and err=0 at all times.
REQ-015 wb_s.dat_sm SHALL be forwarded unconditionally to both masters (validity qualified by each master's ack).
REQ-016 Arbiter SHALL add zero cycles to slave ack latency (write ack same cycle, read ack per slave's one-cycle read delay).
REQ-017 Simultaneous owner cyc drop and other master cyc rise SHALL hand over in that edge per REQ-010.
REQ-018 A master raising stb without cyc SHALL be ignored (no grant, no slave access).

Reset
REQ-019 On rst_n=0: state=IDLE, last_served=m1 (so m0 wins first tie), grant=00, all wb_s outputs 0, timeout counter 0.
REQ-020 Reset asserted mid-transfer SHALL drop wb_s.cyc/stb immediately (asynchronously); no ack reaches either master after reset.
REQ-021 After rst_n release, first arbitration occurs on the first rising edge with rst_n=1.

Configuration
REQ-022 Macro WB_ARB_TIMEOUT_EN defined: 8+-bit counter (width clog2(TIMEOUT+1)) counts cycles with owner stb=1 and wb_s.ack=0; cleared on ack, on stb=0, or on grant change.
REQ-023 With WB_ARB_TIMEOUT_EN: counter reaching TIMEOUT SHALL assert err to owner for exactly one cycle, force wb_s.stb=0 that cycle, clear counter; grant retained until owner drops cyc.
REQ-024 Without WB_ARB_TIMEOUT_EN: no counter instantiated, err to both masters tied 0, TIMEOUT ignored.

Verification
REQ-025 Reset, m0 write cyc/stb/we=1 adr=0x10 dat=0xDEADBEEF sel=0xF -> grant=01 next edge, m0 ack same cycle as wb_s.ack, m1 ack=0.
REQ-026 m0 and m1 raise cyc same edge from IDLE after reset -> grant=01; m0 drops cyc -> grant=10 next edge, no IDLE cycle; repeat tie -> grant=10 first.
REQ-027 m1 reads adr=0x10 after REQ-025 write -> m1 dat_sm=0xDEADBEEF with ack one cycle after stb; m0 ack stays 0 throughout.
REQ-028 m0 holds cyc for 4-beat burst while m1 requests -> grant stays 01 for all 4 acks, m1 sees no ack until granted.
REQ-029 rst_n pulled low mid-read of m1 -> wb_s.cyc/stb=0 and grant=00 before next edge; no ack to m1.
REQ-030 With WB_ARB_TIMEOUT_EN, TIMEOUT=4, slave ack forced 0 -> owner err=1 on 4th waiting cycle for one cycle, wb_s.stb=0 that cycle; without macro, err never asserts.
